// File: rtl/range_window_ctrl.sv
// Sample-window controller that streams a window into a range finder and captures its result.
// Optional threshold alarm is built when RANGE_WINDOW_CTRL_ALARM_EN is defined.
module range_window_ctrl #(
  parameter int WIDTH = 10,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] window_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_err,
  output logic             len_err,
  output logic             alarm
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    CAPTURE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   count;
  logic [LEN_W:0]   count_inc;
  logic             last;

  assign count_inc = count + 1'b1;
  assign last      = (count_inc == {1'b0, len_q});
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      count        <= '0;
      rf_data      <= '0;
      rf_go        <= 1'b0;
      rf_finish    <= 1'b0;
      result       <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      rf_go        <= 1'b0;
      rf_finish    <= 1'b0;
      result_valid <= 1'b0;
      len_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (window_len != '0) begin
              len_q <= window_len;
              count <= '0;
              state <= RUN;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort wins over a same-cycle sample and over start
          if (abort) begin
            state <= IDLE;
          end else if (sample_valid) begin
            count     <= count_inc;
            rf_data   <= sample_in;
            rf_go     <= (count == '0);
            rf_finish <= last;
            if (last) state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= abort ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          result       <= rf_range;
          result_err   <= rf_error;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RANGE_WINDOW_CTRL_ALARM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (state == CAPTURE) begin
      alarm <= (rf_range > threshold);
    end
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_range_window_ctrl.sv
// Scoreboard bench for range_window_ctrl: forwards and captures are queued
// at drive time and retired when the DUT shows them.
module tb_range_window_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] window_len;
  logic       abort;
  logic [9:0] sample_in;
  logic       sample_valid;
  logic [9:0] threshold;
  logic [9:0] rf_data;
  logic       rf_go;
  logic       rf_finish;
  logic [9:0] rf_range;
  logic       rf_error;
  logic       busy;
  logic [9:0] result;
  logic       result_valid;
  logic       result_err;
  logic       len_err;
  logic       alarm;

  range_window_ctrl #(.WIDTH(10), .LEN_W(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .window_len(window_len), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .threshold(threshold), .rf_data(rf_data), .rf_go(rf_go),
    .rf_finish(rf_finish), .rf_range(rf_range), .rf_error(rf_error),
    .busy(busy), .result(result), .result_valid(result_valid),
    .result_err(result_err), .len_err(len_err), .alarm(alarm)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] data;
    logic       go;
    logic       fin;
    int         cyc;
  } fwd_t;

  typedef struct {
    logic [9:0] res;
    logic       err;
    logic       alm;
    int         cyc;
  } res_t;

  fwd_t fwd_q[$];
  res_t res_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_run = 0;
  int m_len = 0;
  int m_cnt = 0;
  int m_idle_cyc = 0;
  logic [9:0] last_res = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_alarm();
`ifdef RANGE_WINDOW_CTRL_ALARM_EN
    return rf_range > threshold;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clock) begin
    if (fwd_q.size() > 0 && fwd_q[0].cyc == cyc) begin
      fwd_t f;
      f = fwd_q.pop_front();
      chk("rf_data", rf_data, f.data);
      chk("rf_go", rf_go, f.go);
      chk("rf_finish", rf_finish, f.fin);
    end else if (rf_go || rf_finish) begin
      chk("stray_strobe", {rf_go, rf_finish}, 0);
    end
    if (result_valid) begin
      if (res_q.size() > 0) begin
        res_t r;
        r = res_q.pop_front();
        chk("result", result, r.res);
        chk("result_err", result_err, r.err);
        chk("alarm", alarm, r.alm);
        chk("result_cyc", cyc, r.cyc);
        last_res = r.res;
      end else begin
        chk("stray_result_valid", result_valid, 0);
      end
    end
  end

  task automatic step(input logic s, input logic [7:0] wl, input logic v,
                      input logic [9:0] d, input logic ab);
    bit idle;
    idle = (m_run == 0) && (cyc >= m_idle_cyc);
    start        = s;
    window_len   = wl;
    sample_valid = v;
    sample_in    = d;
    abort        = ab;
    if (m_run != 0) begin
      if (ab) begin
        m_run = 0;
        m_idle_cyc = cyc + 1;
      end else if (v) begin
        m_cnt++;
        fwd_q.push_back('{d, m_cnt == 1, m_cnt == m_len, cyc + 1});
        if (m_cnt == m_len) begin
          res_q.push_back('{rf_range, rf_error, exp_alarm(), cyc + 3});
          m_run = 0;
          m_idle_cyc = cyc + 3;
        end
      end
    end else if (idle && s && wl != 0) begin
      m_run = 1;
      m_len = wl;
      m_cnt = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy, 0);
    chk("rst_rf_go", rf_go, 0);
    chk("rst_rf_finish", rf_finish, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_result", result, 0);
    chk("rst_result_err", result_err, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0;
    sample_valid = 0;
    abort = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_run = 0;
    m_cnt = 0;
    m_idle_cyc = 0;
    last_res = '0;
    chk_reset_outs();
  endtask

  initial begin
    reset = 1'b1;
    start = 0;
    window_len = 0;
    abort = 0;
    sample_in = 0;
    sample_valid = 0;
    threshold = 10'd100;
    rf_range = 0;
    rf_error = 0;
    @(posedge clock);
    #1;
    do_reset();

    // basic window
    rf_range = 10'd7;
    rf_error = 0;
    step(1, 4, 0, 0, 0);
    chk("busy_run", busy, 1);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 9, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 7, 0);
    idle_steps(5);
    chk("basic_idle", busy, 0);

    // single-sample window, range above threshold
    rf_range = 10'd101;
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 300, 0);
    idle_steps(5);

    // gapped samples, start while busy, error flag
    rf_range = 10'd100;
    rf_error = 1;
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 11, 0);
    step(1, 9, 0, 0, 0);
    step(0, 0, 1, 22, 0);
    idle_steps(2);
    step(0, 0, 1, 33, 0);
    idle_steps(5);
    chk("gap_result_kept", result, 100);

    step(1, 0, 0, 0, 0);
    chk("len_err_pulse", len_err, 1);
    chk("len_err_idle", busy, 0);
    step(0, 0, 0, 0, 0);
    chk("len_err_clear", len_err, 0);

    // abort after two samples, sample in abort cycle dropped
    rf_range = 10'd55;
    rf_error = 0;
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 40, 0);
    step(0, 0, 1, 41, 0);
    step(1, 4, 1, 42, 1);
    chk("abort_busy", busy, 0);
    idle_steps(5);
    chk("abort_result", result, last_res);
    step(0, 0, 0, 0, 1);
    chk("abort_idle_noop", busy, 0);

    // reset in the middle of a window
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 60, 0);
    step(0, 0, 1, 61, 0);
    do_reset();
    idle_steps(2);

    rf_range = 10'd3;
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 2, 0);
    idle_steps(6);

    chk("fwd_q_empty", fwd_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
